// File: rtl/cache_cfg_pkg.sv
// Cache controller build-time defaults.
package cache_cfg_pkg;

  // Default watchdog limit for the command dispatcher, in EXEC cycles
  // counted after the enter cycle.
  localparam int DISPATCH_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/ctrl_types_pkg.sv
// Shared controller types: sub-FSM command status plus the dispatcher's
// operation, response and state encodings.
package ctrl_types_pkg;

  // Status reported by a GET/PUT/DEL sub-FSM: {done, error}.
  typedef struct packed {
    logic done;
    logic error;
  } sub_cmd_t;

  // Request operation; encoding 2'd3 is illegal and never latched.
  typedef enum logic [1:0] {
    OP_GET = 2'd0,
    OP_PUT = 2'd1,
    OP_DEL = 2'd2
  } op_e;

  // Response status returned to the requester.
  typedef enum logic [1:0] {
    RESP_OK      = 2'd0,
    RESP_ERR     = 2'd1,
    RESP_TIMEOUT = 2'd2,
    RESP_ILLEGAL = 2'd3
  } resp_e;

  // Dispatcher top-level states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } dispatch_state_e;

  // Raw request encoding that selects no sub-FSM.
  localparam logic [1:0] OP_ILLEGAL_CODE = 2'd3;

endpackage

// File: rtl/op_dispatch_fsm_if.sv
// Request/response handshakes and sub-FSM enable/status bundle of the
// command dispatcher. slave = dispatcher side, master = environment side.
interface op_dispatch_fsm_if;
  import ctrl_types_pkg::*;

  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;

  logic       get_en;
  logic       put_en;
  logic       del_en;
  logic       get_enter;
  logic       put_enter;
  logic       del_enter;

  sub_cmd_t   get_cmd;
  sub_cmd_t   put_cmd;
  sub_cmd_t   del_cmd;

  logic       resp_valid;
  logic       resp_ready;
  resp_e      resp_status;
  logic       busy;

  modport slave (
    input  req_valid, req_op, get_cmd, put_cmd, del_cmd, resp_ready,
    output req_ready, get_en, put_en, del_en, get_enter, put_enter, del_enter,
    output resp_valid, resp_status, busy
  );

  modport master (
    output req_valid, req_op, get_cmd, put_cmd, del_cmd, resp_ready,
    input  req_ready, get_en, put_en, del_en, get_enter, put_enter, del_enter,
    input  resp_valid, resp_status, busy
  );

endinterface

// File: rtl/dispatch_watchdog.sv
// Saturating EXEC-cycle counter for the dispatcher watchdog.
// The count includes the enter cycle, so on the k-th cycle after enter the
// counter holds k; expired_o flags the cycle whose count equals LIMIT.
module dispatch_watchdog #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int               CNT_W   = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear has priority; otherwise count enabled cycles and hold at LIMIT.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + ONE_C;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i && (cnt_q == LIMIT_C);

endmodule

// File: rtl/op_dispatch_fsm.sv
// Cache controller command dispatcher: accepts one GET/PUT/DEL request,
// enables the matching sub-FSM, collects its done/error status and returns
// a single registered response.
// Optional watchdog: define CTRL_DISPATCH_TIMEOUT_EN to abort a sub-FSM that
// does not report within TIMEOUT_CYCLES post-enter EXEC cycles.
module op_dispatch_fsm
  import ctrl_types_pkg::*;
  import cache_cfg_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DISPATCH_TIMEOUT_CYCLES
) (
  input logic              clk,
  input logic              rst,
  op_dispatch_fsm_if.slave bus
);

  dispatch_state_e state_q, state_d;
  op_e             op_q, op_d;
  resp_e           status_q, status_d;
  logic            enter_q, enter_d;
  sub_cmd_t        sel_cmd;
  logic            wd_expired;

  // A watchdog limit of zero would time out before any report is possible.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("op_dispatch_fsm: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef CTRL_DISPATCH_TIMEOUT_EN
  logic wd_clear;
  logic wd_enable;

  assign wd_clear  = (state_q == ST_IDLE) && bus.req_valid &&
                     (bus.req_op != OP_ILLEGAL_CODE);
  assign wd_enable = (state_q == ST_EXEC);

  dispatch_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (wd_clear),
    .enable_i  (wd_enable),
    .expired_o (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  // Pick the latched op's status; the other two sub-FSMs are never looked at.
  always_comb begin
    sel_cmd = bus.del_cmd;
    unique case (op_q)
      OP_GET:  sel_cmd = bus.get_cmd;
      OP_PUT:  sel_cmd = bus.put_cmd;
      default: sel_cmd = bus.del_cmd;
    endcase
  end

  // Next-state logic: accept in IDLE, wait for report/timeout in EXEC,
  // hold the response in RESP until it is taken.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    status_d = status_q;
    enter_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_op == OP_ILLEGAL_CODE) begin
            status_d = RESP_ILLEGAL;
            state_d  = ST_RESP;
          end else begin
            op_d    = op_e'(bus.req_op);
            enter_d = 1'b1;
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        // Status on the enter cycle belongs to the sub-FSM's previous life.
        if (!enter_q) begin
          if (sel_cmd.error) begin
            status_d = RESP_ERR;
            state_d  = ST_RESP;
          end else if (sel_cmd.done) begin
            status_d = RESP_OK;
            state_d  = ST_RESP;
          end else if (wd_expired) begin
            status_d = RESP_TIMEOUT;
            state_d  = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched op, latched status and first-EXEC-cycle flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_GET;
      status_q <= RESP_OK;
      enter_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      status_q <= status_d;
      enter_q  <= enter_d;
    end
  end

  // All outputs decode from registered state only.
  assign bus.get_en      = (state_q == ST_EXEC) && (op_q == OP_GET);
  assign bus.put_en      = (state_q == ST_EXEC) && (op_q == OP_PUT);
  assign bus.del_en      = (state_q == ST_EXEC) && (op_q == OP_DEL);
  assign bus.get_enter   = bus.get_en && enter_q;
  assign bus.put_enter   = bus.put_en && enter_q;
  assign bus.del_enter   = bus.del_en && enter_q;

  assign bus.req_ready   = (state_q == ST_IDLE);
  assign bus.resp_valid  = (state_q == ST_RESP);
  assign bus.resp_status = status_q;
  assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_op_dispatch_fsm.sv
// Self-checking bench for op_dispatch_fsm: directed scenarios plus random
// transactions checked against a timeline model of each request.
// Define CTRL_DISPATCH_TIMEOUT_EN to exercise the watchdog (limit 4).
module tb_op_dispatch_fsm;
  import ctrl_types_pkg::*;

`ifdef CTRL_DISPATCH_TIMEOUT_EN
  localparam int TO    = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 16;
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  op_dispatch_fsm_if bus ();

  op_dispatch_fsm #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int txn_id = 0;

  // {get_en, put_en, del_en, get_enter, put_enter, del_enter}
  logic [5:0] en_obs;
  // {busy, req_ready, resp_valid}
  logic [2:0] hs_obs;
  assign en_obs = {bus.get_en, bus.put_en, bus.del_en,
                   bus.get_enter, bus.put_enter, bus.del_enter};
  assign hs_obs = {bus.busy, bus.req_ready, bus.resp_valid};

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (txn %0d, t=%0t)",
               tag, obs, exp, txn_id, $time);
    end
  endtask

  // Reference model. A request is described by its op, the post-enter cycle k
  // on which the sub-FSM reports, and the report {done, error} (00 = never).
  function automatic bit model_timeout(int op, int k, logic [1:0] rep);
    return (op != 3) && TO_EN && ((rep == 2'b00) || (k > TO));
  endfunction

  function automatic logic [1:0] model_status(int op, int k, logic [1:0] rep);
    if (op == 3) return 2'd3;
    if (model_timeout(op, k, rep)) return 2'd2;
    return rep[0] ? 2'd1 : 2'd0;
  endfunction

  // Cycles from the accept edge to the first cycle with resp_valid.
  function automatic int model_resp_cycle(int op, int k, logic [1:0] rep);
    if (op == 3) return 1;
    if (model_timeout(op, k, rep)) return 2 + TO;
    return 2 + k;
  endfunction

  // Random status on every sub-FSM, then the selected one gets v.
  task automatic drive_cmds(input int op, input logic [1:0] v);
    bus.get_cmd = sub_cmd_t'(2'($urandom));
    bus.put_cmd = sub_cmd_t'(2'($urandom));
    bus.del_cmd = sub_cmd_t'(2'($urandom));
    case (op)
      0:       bus.get_cmd = sub_cmd_t'(v);
      1:       bus.put_cmd = sub_cmd_t'(v);
      2:       bus.del_cmd = sub_cmd_t'(v);
      default: ;
    endcase
  endtask

  // One full transaction; entered and left on a negedge with the DUT idle.
  task automatic run_txn(input int op, input int k, input logic [1:0] rep,
                         input int bp);
    logic [1:0] exp_st;
    logic [5:0] sel_en;
    logic [5:0] sel_ent;
    logic [1:0] v;
    int         nr;
    exp_st  = model_status(op, k, rep);
    nr      = model_resp_cycle(op, k, rep);
    sel_en  = (op < 3) ? (6'b100000 >> op) : 6'b0;
    sel_ent = (op < 3) ? (6'b000100 >> op) : 6'b0;

    check_eq("idle_hs", {29'd0, hs_obs}, 32'b010);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'(op);
    drive_cmds(op, 2'($urandom));
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_op    = 2'($urandom);

    for (int n = 1; n < nr; n++) begin
      if (n == 1)          v = 2'($urandom);
      else if (n - 1 == k) v = rep;
      else                 v = 2'b00;
      drive_cmds(op, v);
      check_eq("exec_en", {26'd0, en_obs},
               {26'd0, sel_en | ((n == 1) ? sel_ent : 6'b0)});
      check_eq("exec_hs", {29'd0, hs_obs}, 32'b100);
      @(posedge clk);
      @(negedge clk);
    end

    // Response cycle; a request offered now must not be taken.
    drive_cmds(op, 2'($urandom));
    bus.req_valid  = 1'b1;
    bus.req_op     = 2'($urandom_range(0, 2));
    bus.resp_ready = (bp == 0);
    check_eq("resp_hs", {29'd0, hs_obs}, 32'b101);
    check_eq("resp_en", {26'd0, en_obs}, 32'd0);
    check_eq("resp_status", {30'd0, bus.resp_status}, {30'd0, exp_st});
    for (int i = 1; i <= bp; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("bp_hs", {29'd0, hs_obs}, 32'b101);
      check_eq("bp_status", {30'd0, bus.resp_status}, {30'd0, exp_st});
      bus.resp_ready = (i == bp);
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    check_eq("post_hs", {29'd0, hs_obs}, 32'b010);
    $display("txn %0d: op=%0d k=%0d rep=%b bp=%0d status=%0d model=%0d",
             txn_id, op, k, rep, bp, bus.resp_status, exp_st);
    txn_id++;
  endtask

  initial begin
    int         op;
    int         k;
    int         bp;
    logic [1:0] rep;

    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_op     = 2'd0;
    bus.resp_ready = 1'b0;
    drive_cmds(3, 2'b00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_en", {26'd0, en_obs}, 32'd0);
    check_eq("reset_hs", {29'd0, hs_obs}, 32'b010);
    check_eq("reset_status", {30'd0, bus.resp_status}, 32'd0);
    rst = 1'b0;

    run_txn(2, 2, 2'b10, 0);  // DEL hit: enter, START, DELETE with done
    run_txn(2, 1, 2'b01, 0);  // DEL miss: error on second EXEC cycle
    run_txn(0, 3, 2'b11, 0);  // error beats done
    run_txn(3, 1, 2'b00, 0);  // illegal op
    run_txn(1, 1, 2'b10, 5);  // response backpressure
`ifdef CTRL_DISPATCH_TIMEOUT_EN
    run_txn(1, 0, 2'b00, 0);  // PUT never reports: timeout
    run_txn(1, TO, 2'b10, 0); // done on the limit cycle beats timeout
    run_txn(2, TO, 2'b01, 1); // error on the limit cycle beats timeout
`endif

    // Reset in the middle of EXEC.
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd0;
    drive_cmds(0, 2'b00);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_eq("rst_mid_enter", {26'd0, en_obs}, 32'b100100);
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_mid_exec", {26'd0, en_obs}, 32'b100000);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_mid_en", {26'd0, en_obs}, 32'd0);
    check_eq("rst_mid_hs", {29'd0, hs_obs}, 32'b010);
    check_eq("rst_mid_status", {30'd0, bus.resp_status}, 32'd0);
    rst = 1'b0;
    run_txn(0, 2, 2'b10, 0);  // fresh get_enter after reset

    // Random transactions.
    repeat (60) begin
      op  = int'($urandom_range(0, 3));
      k   = TO_EN ? int'($urandom_range(1, TO + 2)) : int'($urandom_range(1, 8));
      rep = 2'($urandom);
      if (!TO_EN && rep == 2'b00) rep = 2'b10;
      bp  = int'($urandom_range(0, 3));
      run_txn(op, k, rep, bp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
